// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One radix-2 step per cycle in CALC, then a FIX cycle that sign-corrects and commits.
module muldiv_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] RTYPE_OP = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUop,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mf_valid,
  output logic [WIDTH-1:0] mf_data
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   upper_q, upper_d;
  logic [WIDTH-1:0]   lower_q, lower_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic               mf_valid_q, mf_valid_d;
  logic [WIDTH-1:0]   mf_data_q, mf_data_d;

  logic               accept;
  logic               signed_op;
  logic               div_code;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign accept    = in_valid && in_ready && (ALUop == RTYPE_OP);
  assign signed_op = (FuncCode == F_MULT) || (FuncCode == F_DIV);
  assign div_code  = (FuncCode == F_DIV) || (FuncCode == F_DIVU);
  assign a_mag     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

  // Multiply: upper:lower is the running product, multiplier bits consumed from lower[0].
  assign addend    = lower_q[0] ? mcand_q : '0;
  assign mul_sum   = {1'b0, upper_q} + {1'b0, addend};

  // Divide: upper is the partial remainder, dividend bits shifted out of lower's MSB.
  // With a zero divisor every step subtracts nothing, so upper ends up holding |dividend|.
  assign div_shift = {upper_q, lower_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mcand_q};
  assign div_diff  = div_shift[WIDTH-1:0] - mcand_q;

  assign prod_fix  = neg_q ? -{upper_q, lower_q} : {upper_q, lower_q};
  assign quo_fix   = neg_q ? -lower_q : lower_q;
  assign rem_fix   = neg_rem_q ? -upper_q : upper_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    mcand_d    = mcand_q;
    upper_d    = upper_q;
    lower_d    = lower_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    mf_valid_d = 1'b0;
    mf_data_d  = mf_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (FuncCode)
            F_MTHI: hi_d = op_a;
            F_MTLO: lo_d = op_a;
            F_MFHI: begin
              mf_data_d  = hi_q;
              mf_valid_d = 1'b1;
            end
            F_MFLO: begin
              mf_data_d  = lo_q;
              mf_valid_d = 1'b1;
            end
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d   = S_CALC;
              cnt_d     = '0;
              is_div_d  = div_code;
              neg_d     = signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              neg_rem_d = signed_op && op_a[WIDTH-1];
              dz_d      = (op_b == '0);
              upper_d   = '0;
              lower_d   = div_code ? a_mag : b_mag;
              mcand_d   = div_code ? b_mag : a_mag;
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            upper_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lower_d = {lower_q[WIDTH-2:0], div_ge};
          end else begin
            upper_d = mul_sum[WIDTH:1];
            lower_d = {mul_sum[0], lower_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d  = dz_q ? '1 : quo_fix;
            hi_d  = rem_fix;
            dbz_d = dz_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      mcand_q    <= '0;
      upper_q    <= '0;
      lower_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      mf_valid_q <= 1'b0;
      mf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      mcand_q    <= mcand_d;
      upper_q    <= upper_d;
      lower_q    <= lower_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      mf_valid_q <= mf_valid_d;
      mf_data_q  <= mf_data_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign mf_valid    = mf_valid_q;
  assign mf_data     = mf_data_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Decodes the R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO function codes that the combinational ALU control does not handle.
- Sits beside the ALU in the execute stage and stalls issue via a ready/valid handshake while an operation iterates.
- Parametrised in datapath width and supports a pipeline flush that aborts an in-flight operation.

Parameters:
WIDTH, 32, operand/HI/LO width in bits; minimum 4.
RTYPE_OP, 4'b1111, ALUop value marking an R-type instruction; FuncCode is decoded only when ALUop equals this value.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  instruction present this cycle.
in_ready  out  1  unit can accept; equals !busy && !flush.
ALUop  in  4  ALU operation type from the control unit.
FuncCode  in  6  instruction function field.
op_a  in  WIDTH  rs operand (multiplicand/dividend/MT source).
op_b  in  WIDTH  rt operand (multiplier/divisor).
flush  in  1  abort in-flight operation (exception/branch squash).
busy  out  1  mul/div iterating.
done  out  1  one-cycle pulse: HI/LO just updated by mul/div.
div_by_zero  out  1  one-cycle pulse coincident with done for a DIV/DIVU whose divisor is 0.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
mf_valid  out  1  one-cycle pulse: mf_data valid.
mf_data  out  WIDTH  MFHI/MFLO result, registered.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, div_by_zero=0, mf_valid=0, mf_data=0; state IDLE; counter 0. Reset mid-operation discards the operation immediately.
- Accept: an instruction is accepted on an edge where in_valid && in_ready && ALUop==RTYPE_OP.
- Recognised codes: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO. All other codes, or ALUop!=RTYPE_OP, are ignored with no state change.
- MTHI/MTLO: hi/lo <= op_a at the accepting edge. Single cycle; busy stays 0.
- MFHI/MFLO: mf_data <= current hi/lo and mf_valid=1 for the cycle after the accepting edge. An MT and an MF can never be accepted on the same edge; only one instruction is accepted per edge.
- States: IDLE -> CALC on mul/div accept. CALC runs for WIDTH edges, one radix-2 shift-add or restoring-subtract step per edge. CALC -> FIX after the WIDTH-th step. FIX -> IDLE on the next edge, which writes hi/lo and sign-corrects.
- Timing: if the accept is at edge 0, busy=1 in the cycles after edges 0..W, and done=1 in the cycle after edge W+1 (busy=0 in that cycle). In_ready is therefore low for W+1 cycles, and back-to-back operations are allowed from the done cycle.
- Signed ops: operate on magnitudes and negate the result in FIX. MULT/MULTU give the 2*WIDTH product, {hi,lo} = product.
- DIV/DIVU: lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- DIV of the most-negative value by -1: lo = most-negative, hi = 0.
- Divide by zero: takes the same latency; lo = all-ones, hi = dividend (op_a as given); div_by_zero pulses with done.
- Operands are captured at accept; later changes on op_a/op_b have no effect.
- Flush: flush=1 forces in_ready=0. In CALC/FIX it returns the unit to IDLE at that edge: busy=0 next cycle, hi/lo unchanged, no done. Flush in IDLE has no effect. Flush has priority over a simultaneous in_valid, so nothing is accepted.
- A pending mf_valid or done pulse already scheduled for the next cycle is not cancelled by flush.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF (WIDTH=32) -> busy 33 cycles, done 33 cycles after the accept edge, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1 with done.
- MTLO 0x1234 then MFLO -> mf_valid the cycle after the MFLO accept, mf_data=0x1234. MFHI held with in_valid during a MULT -> in_ready=0 until the done cycle, then returns the new hi.
- Flush asserted on the 10th busy cycle of MULT 5*6 (prior hi/lo=0xA/0xB) -> busy=0 next cycle, no done, hi=0xA, lo=0xB. Repeat with rst instead -> hi=lo=0 and all pulses 0.
- ALUop=0010 with FuncCode=011000, and ALUop=1111 with FuncCode=100000 -> no state change, busy stays 0.
